tone_burst_detector: RTL

Receive-side counterpart of the game's square-wave sound-effect generators. Samples a 1-bit audio line, which is either a generator output looped back or an external tone source. Measures the high and low half-periods, the edge count and the duration of each tone burst. After a burst ends, presents the results with a one-cycle valid pulse. Used for in-system audio self-test and for sound-triggered debug.

---
 rtl/tone_burst_detector.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tone_burst_detector.sv
// Tone burst detector: times the high/low half-periods, edge count and length of square-wave bursts on a 1-bit line.
// Latency: results pulse out SILENCE_CYCLES after the last edge; no backpressure, results hold until the next reported burst.
module tone_burst_detector #(
  parameter int CNT_W          = 17,
  parameter int DUR_W          = 24,
  parameter int SILENCE_CYCLES = 65536,
  parameter int MIN_EDGES      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             audioIn,
  output logic             active,
  output logic             burstValid,
  output logic [CNT_W-1:0] halfPeriodHigh,
  output logic [CNT_W-1:0] halfPeriodLow,
  output logic [15:0]      edgeCount,
  output logic [DUR_W-1:0] burstLength,
  output logic             overflow,
  output logic             stuckHigh
);

  localparam logic [CNT_W-1:0] RUN_MAX  = '1;
  localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SIL      = CNT_W'(SILENCE_CYCLES);
  localparam logic [DUR_W-1:0] DUR_MAX  = '1;
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
  localparam logic [15:0]      EDGE_MIN = 16'(MIN_EDGES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_sync1, r_sync2, r_prev;
  logic w_edge, w_rise, w_fall;
  logic w_start, w_end;

  logic [CNT_W-1:0] r_run, r_hi, r_lo;
  logic [DUR_W-1:0] r_dur, r_last_dur;
  logic [15:0]      r_edges;
  logic             r_ovf;

  logic             w_dur_sat, w_run_sat, w_ovf_nxt, w_report_ok;
  logic [15:0]      w_edges_nxt;

  logic             r_burst_valid;
  logic [CNT_W-1:0] r_out_hi, r_out_lo;
  logic [15:0]      r_out_edges;
  logic [DUR_W-1:0] r_out_len;
  logic             r_out_ovf, r_out_stuck;

  // Two-flop synchronizer; r_prev starts at 0 so a line high at reset release reads as a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= audioIn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 ^ r_prev;
  assign w_rise = w_edge & r_sync2;
  assign w_fall = w_edge & ~r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_start     = 1'b1;
          w_state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (!w_edge && (r_run == SIL)) begin
          w_end       = 1'b1;
          w_state_nxt = REPORT;
        end
      end
      REPORT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign active = (r_state == MEASURE);

  assign w_dur_sat   = (r_dur == DUR_MAX);
  assign w_run_sat   = (r_run == RUN_MAX);
  assign w_ovf_nxt   = r_ovf | w_dur_sat | (~w_edge & w_run_sat);
  assign w_edges_nxt = (r_edges == 16'hFFFF) ? r_edges : r_edges + 16'd1;
  assign w_report_ok = (r_edges >= EDGE_MIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run      <= '0;
      r_dur      <= '0;
      r_last_dur <= '0;
      r_edges    <= '0;
      r_ovf      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_run      <= RUN_ONE;
            r_dur      <= DUR_ONE;
            r_last_dur <= '0;
            r_edges    <= 16'd1;
            r_ovf      <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
          end
        end
        MEASURE: begin
          r_dur <= w_dur_sat ? r_dur : r_dur + DUR_ONE;
          r_ovf <= w_ovf_nxt;
          if (w_edge) begin
            r_run      <= RUN_ONE;
            r_edges    <= w_edges_nxt;
            r_last_dur <= r_dur;
            if (w_fall) begin
              r_hi <= r_run;
            end else begin
              r_lo <= r_run;
            end
          end else begin
            r_run <= w_run_sat ? r_run : r_run + RUN_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Results load on the MEASURE->REPORT edge so they are already visible while burstValid is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_burst_valid <= 1'b0;
      r_out_hi      <= '0;
      r_out_lo      <= '0;
      r_out_edges   <= '0;
      r_out_len     <= '0;
      r_out_ovf     <= 1'b0;
      r_out_stuck   <= 1'b0;
    end else begin
      r_burst_valid <= 1'b0;
      if (w_end && w_report_ok) begin
        r_burst_valid <= 1'b1;
        r_out_hi      <= r_hi;
        r_out_lo      <= r_lo;
        r_out_edges   <= r_edges;
        r_out_len     <= r_last_dur;
        r_out_ovf     <= w_ovf_nxt;
        r_out_stuck   <= r_sync2;
      end
    end
  end

  assign burstValid     = r_burst_valid;
  assign halfPeriodHigh = r_out_hi;
  assign halfPeriodLow  = r_out_lo;
  assign edgeCount      = r_out_edges;
  assign burstLength    = r_out_len;
  assign overflow       = r_out_ovf;
  assign stuckHigh      = r_out_stuck;

endmodule
